// File: rtl/ex_mem_stage_buf.sv
// EX->MEM stage: 2-entry skid buffer with valid/ready handshake and flush.
// Optional statistics counters are built when EX_MEM_STATS_EN is defined.
module ex_mem_stage_buf #(
  parameter int XLEN   = 32,
  parameter int RD_W   = 5,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_alu_result,
  input  logic [XLEN-1:0]   in_rs2_data,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [3:0]        in_ctrl,
  input  logic              in_branch,
  input  logic              in_zero,
  input  logic              in_take,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_alu_result,
  output logic [XLEN-1:0]   out_rs2_data,
  output logic [RD_W-1:0]   out_rd,
  output logic [3:0]        out_ctrl,
  output logic              out_branch,
  output logic              out_zero,
  output logic              out_mispredict,
  output logic [STAT_W-1:0] stat_stall,
  output logic [STAT_W-1:0] stat_flush
);

  typedef struct packed {
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] rs2;
    logic [RD_W-1:0] rd;
    logic [3:0]      ctrl;
    logic            branch;
    logic            zero;
    logic            mispredict;
  } ent_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state_q, state_d;
  ent_t   main_q, skid_q, in_ent, head;
  logic   in_fire, out_fire;
  logic   load_main, load_skid, from_skid;

  assign in_ent.alu        = in_alu_result;
  assign in_ent.rs2        = in_rs2_data;
  assign in_ent.rd         = in_rd;
  assign in_ent.ctrl       = in_ctrl;
  assign in_ent.branch     = in_branch;
  assign in_ent.zero       = in_zero;
  assign in_ent.mispredict = in_branch && (in_take != in_zero);

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    load_main = 1'b0;
    load_skid = 1'b0;
    from_skid = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: if (in_fire) begin
          state_d   = ONE;
          load_main = 1'b1;
        end
        ONE: if (in_fire && out_fire) begin
          load_main = 1'b1;
        end else if (in_fire) begin
          state_d   = FULL;
          load_skid = 1'b1;
        end else if (out_fire) begin
          state_d   = EMPTY;
        end
        FULL: if (out_fire) begin
          state_d   = ONE;
          load_main = 1'b1;
          from_skid = 1'b1;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main) main_q <= from_skid ? skid_q : in_ent;
      if (load_skid) skid_q <= in_ent;
    end
  end

  // Empty stage presents an all-zero NOP downstream.
  always_comb begin
    in_ready  = (state_q != FULL) && reset;
    out_valid = (state_q != EMPTY);
    head      = out_valid ? main_q : '0;
  end

  assign out_alu_result = head.alu;
  assign out_rs2_data   = head.rs2;
  assign out_rd         = head.rd;
  assign out_ctrl       = head.ctrl;
  assign out_branch     = head.branch;
  assign out_zero       = head.zero;
  assign out_mispredict = head.mispredict;

`ifdef EX_MEM_STATS_EN
  logic [STAT_W-1:0] stall_q, flush_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (out_valid && !out_ready && !(&stall_q))
        stall_q <= stall_q + 1'b1;
      if (flush && (state_q != EMPTY) && !(&flush_q))
        flush_q <= flush_q + 1'b1;
    end
  end

  assign stat_stall = stall_q;
  assign stat_flush = flush_q;
`else
  assign stat_stall = '0;
  assign stat_flush = '0;
`endif

endmodule

// File: tb/tb_ex_mem_stage_buf.sv
// Bench for ex_mem_stage_buf: directed scenarios then random traffic,
// all checked against a queue-based model of the stage.
module tb_ex_mem_stage_buf;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] in_alu_result, in_rs2_data;
  logic [4:0]  in_rd;
  logic [3:0]  in_ctrl;
  logic        in_branch, in_zero, in_take, flush;
  logic        out_valid, out_ready;
  logic [31:0] out_alu_result, out_rs2_data;
  logic [4:0]  out_rd;
  logic [3:0]  out_ctrl;
  logic        out_branch, out_zero, out_mispredict;
  logic [15:0] stat_stall, stat_flush;

  ex_mem_stage_buf dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_result(in_alu_result), .in_rs2_data(in_rs2_data),
    .in_rd(in_rd), .in_ctrl(in_ctrl),
    .in_branch(in_branch), .in_zero(in_zero), .in_take(in_take),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_result(out_alu_result), .out_rs2_data(out_rs2_data),
    .out_rd(out_rd), .out_ctrl(out_ctrl),
    .out_branch(out_branch), .out_zero(out_zero),
    .out_mispredict(out_mispredict),
    .stat_stall(stat_stall), .stat_flush(stat_flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic [3:0]  ctrl;
    logic        br;
    logic        z;
    logic        mp;
  } beat_t;

  beat_t q[$];
  int    checks = 0;
  int    failures = 0;
  int    m_stall = 0;
  int    m_flush = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t cur_beat();
    beat_t b;
    b.alu  = in_alu_result;
    b.rs2  = in_rs2_data;
    b.rd   = in_rd;
    b.ctrl = in_ctrl;
    b.br   = in_branch;
    b.z    = in_zero;
    b.mp   = in_branch && (in_take != in_zero);
    return b;
  endfunction

  task automatic check_outputs();
    beat_t e;
    bit    v;
    v = (q.size() != 0);
    if (v) e = q[0];
    else e = '{default: '0};
    chk("out_valid", out_valid, v);
    chk("in_ready", in_ready, (q.size() < 2) && reset);
    chk("out_alu", out_alu_result, e.alu);
    chk("out_rs2", out_rs2_data, e.rs2);
    chk("out_rd", out_rd, e.rd);
    chk("out_ctrl", out_ctrl, e.ctrl);
    chk("out_branch", out_branch, e.br);
    chk("out_zero", out_zero, e.z);
    chk("out_mispredict", out_mispredict, e.mp);
`ifdef EX_MEM_STATS_EN
    chk("stat_stall", stat_stall, m_stall);
    chk("stat_flush", stat_flush, m_flush);
`else
    chk("stat_stall", stat_stall, 0);
    chk("stat_flush", stat_flush, 0);
`endif
  endtask

  // One clock: check at negedge, then advance the model at posedge.
  task automatic tick();
    bit inf, outf;
    @(negedge clk);
    check_outputs();
    inf  = in_valid && (q.size() < 2) && reset;
    outf = (q.size() != 0) && out_ready;
    if (q.size() != 0 && !out_ready && m_stall < 65535) m_stall++;
    @(posedge clk);
    if (flush) begin
      if (q.size() != 0 && m_flush < 65535) m_flush++;
      q.delete();
    end else begin
      if (outf) void'(q.pop_front());
      if (inf) q.push_back(cur_beat());
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] alu);
    in_valid      = v;
    in_alu_result = alu;
    in_rs2_data   = $urandom;
    in_rd         = 5'($urandom);
    in_ctrl       = 4'($urandom);
    in_branch     = 1'b0;
    in_zero       = 1'($urandom);
    in_take       = 1'($urandom);
  endtask

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 32'h0);
    tick();
    tick();
    reset = 1'b1;
    // Streaming at full rate.
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 32'(i));
      tick();
      chk("s1_alu", out_alu_result, 32'(i));
      chk("s1_in_ready", in_ready, 1'b1);
    end
    drive(1'b0, 32'h0);
    tick();
    tick();
    // Back-pressure fills the skid entry.
    out_ready = 1'b0;
    drive(1'b1, 32'hA);
    tick();
    drive(1'b1, 32'hB);
    tick();
    tick();
    tick();
    chk("s2_in_ready", in_ready, 1'b0);
    chk("s2_head", out_alu_result, 32'hA);
    out_ready = 1'b1;
    drive(1'b0, 32'h0);
    chk("s2_head_a", out_alu_result, 32'hA);
    tick();
    chk("s2_head_b", out_alu_result, 32'hB);
    tick();
    tick();
    // Mispredict flag travels with its beat.
    drive(1'b1, 32'h30);
    in_branch = 1'b1; in_take = 1'b1; in_zero = 1'b0;
    tick();
    chk("s3_mp1", out_mispredict, 1'b1);
    drive(1'b1, 32'h31);
    in_branch = 1'b1; in_take = 1'b1; in_zero = 1'b1;
    tick();
    chk("s3_mp0", out_mispredict, 1'b0);
    drive(1'b0, 32'h0);
    tick();
    // Flush while full with a beat offered.
    out_ready = 1'b0;
    drive(1'b1, 32'hA);
    tick();
    drive(1'b1, 32'hB);
    tick();
    drive(1'b1, 32'hC);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0);
    chk("s4_valid", out_valid, 1'b0);
    chk("s4_alu", out_alu_result, 32'h0);
    chk("s4_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    tick();
    tick();
    // Asynchronous reset while full.
    out_ready = 1'b0;
    drive(1'b1, 32'h51);
    tick();
    drive(1'b1, 32'h52);
    tick();
    tick();
    #1;
    reset = 1'b0;
    #1;
    chk("s5_valid", out_valid, 1'b0);
    chk("s5_alu", out_alu_result, 32'h0);
    chk("s5_in_ready", in_ready, 1'b0);
    q.delete();
    m_stall = 0;
    m_flush = 0;
    tick();
    tick();
    reset = 1'b1;
    drive(1'b0, 32'h0);
    tick();
    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), $urandom);
      in_branch = 1'($urandom);
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      tick();
    end
    flush = 1'b0;
    drive(1'b0, 32'h0);
    out_ready = 1'b1;
    tick();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
